fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the word width, matching the shared FIFO.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the max words one grant may transfer (1..256).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  SHALL be per-requester write-valid; word i is offered while req[i]=1.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  SHALL hold requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  SHALL mark requester i's current word as the last of its packet.
REQ-009 gnt  output  NUM_REQ  SHALL be one-hot-or-zero; gnt[i]=1 means requester i's word transfers this cycle.
REQ-010 fifo_full  input  1  SHALL be the shared FIFO's full flag.
REQ-011 fifo_wr_en  output  1  SHALL be the FIFO write enable.
REQ-012 fifo_data  output  DATA_WIDTH  SHALL be the FIFO write data.
REQ-013 busy  output  1  SHALL be 1 while a packet is locked to an owner.
REQ-014 owner  output  clog2(NUM_REQ)  SHALL give the current or most recent grant index.

Function
REQ-015 Handshake: a transfer occurs on requester i in a cycle iff gnt[i]=1; gnt, fifo_wr_en and fifo_data SHALL be combinational from state, req, req_last and fifo_full (zero latency).
REQ-016 fifo_wr_en SHALL equal OR of gnt; fifo_data SHALL equal the granted requester's word, and all-zero when no grant.
REQ-017 gnt SHALL be all-zero whenever fifo_full=1 (the FIFO writes RAM unconditionally, so no write while full).
REQ-018 FSM states: IDLE, LOCK; registers: state, owner, rr_ptr (clog2(NUM_REQ)), beat_cnt (clog2(MAX_BURST)+1 bits).
REQ-019 IDLE: if fifo_full=0 and any req, grant the first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; owner<=i.
REQ-020 IDLE grant with req_last[i]=1 or MAX_BURST=1: stay IDLE, rr_ptr<=(i+1) mod NUM_REQ.
REQ-021 IDLE grant otherwise: go LOCK, beat_cnt<=1.
REQ-022 LOCK: gnt[owner]=req[owner] & ~fifo_full; all other gnt bits SHALL be 0 regardless of their req.
REQ-023 LOCK transfer: beat_cnt<=beat_cnt+1; if req_last[owner]=1 or beat_cnt+1=MAX_BURST, go IDLE and rr_ptr<=(owner+1) mod NUM_REQ.
REQ-024 LOCK with req[owner]=0 or fifo_full=1: hold state, owner and beat_cnt (packet stays atomic, no preemption).
REQ-025 busy SHALL be 1 iff state=LOCK.
REQ-026 No requests in IDLE: no grant, all registers hold.
REQ-027 rr_ptr wrap: owner NUM_REQ-1 completing SHALL set rr_ptr to 0.
REQ-028 Burst cap: a packet longer than MAX_BURST SHALL be split; the owner re-arbitrates after MAX_BURST words.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, independent of clk.
REQ-030 During and after reset with req=0: gnt=0, fifo_wr_en=0, fifo_data=0, busy=0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the first post-reset grant follows REQ-019 from rr_ptr=0.

Verification
REQ-032 Reset, then req=4'b1111, all req_last=1, fifo_full=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,..., busy=0 throughout.
REQ-033 Requester 2 sends 5-word packet (last on word 5) while req[0]=1 -> gnt[2] for 5 consecutive cycles, busy=1 for 4 post-edge cycles, then gnt[0]; fifo_data equals requester 2's words in order.
REQ-034 MAX_BURST=16, requester 1 sends 20 words, no req_last until word 20, req[3]=1 -> 16 words to 1, then requester 3 packet, then remaining 4 from 1.
REQ-035 fifo_full=1 for 3 cycles mid-packet -> gnt=0 and fifo_wr_en=0 those cycles, beat_cnt and owner unchanged, transfer resumes with next word, no word lost or duplicated.
REQ-036 rst_n pulsed low asynchronously (between clock edges) during LOCK owner=3 -> busy drops immediately; with req=4'b1010 after release, first grant goes to requester 1.
REQ-037 Owner deasserts req for 2 cycles in LOCK while others request -> gnt=0 those cycles, busy=1, same owner resumes.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin write arbiter for a shared FIFO.
// Grants are combinational; a multi-word packet locks its owner until last or burst cap.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW        = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy,
    output logic [OW-1:0]                 owner
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [OW-1:0] scan_idx;
    logic          scan_vld;
    logic [OW-1:0] cand;
    int            pos;

    logic [OW-1:0] gnt_idx;
    logic          gnt_vld;

    logic [BW-1:0] beat_inc;
    logic          burst_end;

    // Index following i, wrapping back to requester 0.
    function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Round-robin scan: first requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = rr_ptr_q;
        pos      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = OW'(pos);
            if (!scan_vld && req[cand]) begin
                scan_vld = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // Pick the granted requester; a full FIFO or locked idle owner blocks all.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = owner_q;
        if (!fifo_full) begin
            unique case (state_q)
                S_IDLE: begin
                    gnt_vld = scan_vld;
                    gnt_idx = scan_idx;
                end
                S_LOCK: begin
                    gnt_vld = req[owner_q];
                    gnt_idx = owner_q;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_idx = owner_q;
                end
            endcase
        end
    end

    // One-hot grant vector and write-data mux, zero when nothing moves.
    always_comb begin
        gnt       = '0;
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vld && (gnt_idx == OW'(i))) begin
                gnt[i]    = 1'b1;
                fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wr_en = |gnt;
    assign busy       = (state_q == S_LOCK);
    assign owner      = owner_q;

    assign beat_inc  = beat_cnt_q + 1'b1;
    assign burst_end = (beat_inc == BW'(MAX_BURST));

    // Next-state: open a lock on a multi-word start, close on last word or cap.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    if (req_last[gnt_idx] || (MAX_BURST == 1)) begin
                        rr_ptr_d = ptr_after(gnt_idx);
                    end else begin
                        state_d    = S_LOCK;
                        beat_cnt_d = BW'(1);
                    end
                end
            end
            S_LOCK: begin
                if (gnt_vld) begin
                    beat_cnt_d = beat_inc;
                    if (req_last[owner_q] || burst_end) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = ptr_after(owner_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any lock at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a packet-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic            busy;
    logic [1:0]      owner;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data (fifo_data),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: packet lock flag, owner, next-scan start, words in burst.
    bit m_lock;
    int m_owner;
    int m_rr;
    int m_cnt;

    int          pend [N];
    int unsigned seq  [N];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wd(int i, int w);
        logic [7:0] tag;
        tag = 8'(8'hA0 + i);
        return {tag, 56'(w)};
    endfunction

    task automatic m_reset();
        m_lock  = 0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
    endtask

    function automatic int m_pick();
        if (fifo_full) return -1;
        if (m_lock) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic drv(int i, bit r, bit l, logic [63:0] d);
        req[i]             = r;
        req_last[i]        = l;
        req_data[i*DW +: DW] = d;
    endtask

    // Called at a negedge with inputs driven; checks, advances model, waits a cycle.
    task automatic step(output int g, output logic [N-1:0] og,
                        output logic [DW-1:0] od);
        logic [63:0] eg;
        logic [63:0] ed;
        #1;
        g  = m_pick();
        og = gnt;
        od = fifo_data;
        eg = (g >= 0) ? (64'd1 << g) : 64'd0;
        ed = (g >= 0) ? req_data[g*DW +: DW] : 64'd0;
        chk("gnt", gnt, eg);
        chk("wr_en", fifo_wr_en, 64'(g >= 0));
        chk("data", fifo_data, ed);
        chk("busy", busy, 64'(m_lock));
        chk("owner", owner, 64'(m_owner));
        if (g >= 0) begin
            if (!m_lock) begin
                m_owner = g;
                if (req_last[g]) begin
                    m_rr = (g + 1) % N;
                end else begin
                    m_lock = 1;
                    m_cnt  = 1;
                end
            end else begin
                m_cnt++;
                if (req_last[g] || m_cnt == MB) begin
                    m_lock = 0;
                    m_rr   = (g + 1) % N;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int            g;
        logic [N-1:0]  og;
        logic [DW-1:0] od;
        int            w1;
        int            pos3;
        bit            done3;
        logic [3:0]    exp32 [8];

        // Back-to-back single-word packets rotate evenly.
        exp32 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < N; i++) drv(i, 1, 1, wd(i, 0));
        for (int c = 0; c < 8; c++) begin
            step(g, og, od);
            chk("rr_seq", og, exp32[c]);
        end

        // Five-word packet from requester 2 holds off requester 0.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            drv(2, 1, w == 5, wd(2, w));
            if (w == 2) drv(0, 1, 1, wd(0, 9));
            step(g, og, od);
            chk("pkt5_gnt", og, 4'b0100);
            chk("pkt5_data", od, wd(2, w));
        end
        drv(2, 0, 0, 0);
        step(g, og, od);
        chk("pkt5_next", og, 4'b0001);

        // 20-word packet is split at the burst cap around requester 3.
        do_reset();
        w1    = 1;
        pos3  = -1;
        done3 = 0;
        for (int c = 0; c < 40 && (w1 <= 20 || !done3); c++) begin
            drv(1, w1 <= 20, w1 == 20, wd(1, w1));
            drv(3, !done3, 1, wd(3, 0));
            step(g, og, od);
            if (og == 4'b0010) w1++;
            if (og == 4'b1000 && !done3) begin
                done3 = 1;
                pos3  = w1 - 1;
            end
        end
        chk("cap_split", 64'(pos3), 16);
        chk("cap_total", 64'(w1 - 1), 20);

        // FIFO full for 3 cycles, then owner stalls 2 cycles, packet stays locked.
        do_reset();
        w1 = 1;
        for (int c = 0; c < 24 && w1 <= 8; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            drv(1, !(c == 6 || c == 7), w1 == 8, wd(1, w1));
            if (c >= 1) begin
                drv(0, 1, 1, wd(0, 7));
                drv(2, 1, 1, wd(2, 7));
            end
            step(g, og, od);
            if (c >= 2 && c <= 4) chk("full_gnt", og, 0);
            if (c == 6 || c == 7) chk("stall_gnt", og, 0);
            if (og == 4'b0010) begin
                chk("hold_data", od, wd(1, w1));
                w1++;
            end
        end
        chk("hold_words", 64'(w1 - 1), 8);
        drv(1, 0, 0, 0);
        fifo_full = 1'b0;
        step(g, og, od);
        chk("hold_after", og, 4'b0100);

        // Asynchronous reset mid-lock abandons the owner.
        do_reset();
        drv(3, 1, 0, wd(3, 1));
        step(g, og, od);
        drv(3, 1, 0, wd(3, 2));
        step(g, og, od);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        m_reset();
        req      = 4'b1010;
        req_last = 4'b1010;
        rst_n    = 1'b1;
        step(g, og, od);
        chk("arst_first", og, 4'b0010);

        // Random traffic with stalls, full FIFO, long packets and reset pulses.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            seq[i]  = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 3) == 0) begin
                    pend[i] = int'($urandom_range(1, 24));
                end
                drv(i, pend[i] > 0 && $urandom_range(0, 9) != 0,
                    pend[i] == 1, wd(i, int'(seq[i])));
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                m_reset();
            end
            step(g, og, od);
            if (g >= 0) begin
                seq[g]++;
                pend[g]--;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
